// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared constants, binary32 field layout and FSM states for the add/sub back end
package fp_pkg;

  localparam int MANT_W = 24;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  localparam logic [7:0] EXP_MAX = 8'hFF;
  localparam int EXP_BIAS = 127;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  bexp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    OUT
  } state_e;

endpackage

// File: rtl/fp_lzc24.sv
// rtl/fp_lzc24.sv - combinational 24-bit leading-zero counter, 24 for an all-zero input
module fp_lzc24
  import fp_pkg::*;
(
  input  logic [MANT_W-1:0] mant,
  output logic [4:0]        count
);

  // Scanning upward lets the highest set bit overwrite every lower hit.
  always_comb begin
    count = 5'd24;
    for (int i = 0; i < MANT_W; i++) begin
      if (mant[i]) count = 5'(MANT_W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_norm_pack.sv
// rtl/fp_norm_pack.sv - left-normalise the adder mantissa and pack a binary32 result
// FP_NORM_LZC_EN selects a single-cycle leading-zero-count shifter instead of one bit per cycle.
module fp_norm_pack
  import fp_pkg::*;
#(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic              in_carry,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic              in_sign,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data
);

  state_e            state;
  state_e            state_nxt;
  logic [MANT_W-1:0] mant;
  logic [EXP_W+1:0]  work_exp;
  logic              sign;
  logic              pass;

  logic [EXP_W+1:0]  start_exp;
  logic [MANT_W-1:0] n_mant;
  logic [EXP_W+1:0]  n_exp;
  logic              done;
  fp32_t             word;

  // Exponent 0 encodes a denormal operand whose true scale matches exponent 1.
  assign start_exp = {2'b00, (in_exp == '0) ? EXP_W'(1) : in_exp}
                   + {{(EXP_W + 1){1'b0}}, in_carry};

`ifdef FP_NORM_LZC_EN
  logic [4:0]       lzc;
  logic [4:0]       shift;
  logic [EXP_W+1:0] exp_lim;

  fp_lzc24 u_lzc (
    .mant  (mant),
    .count (lzc)
  );

  // Never shift below exponent 1; what remains unnormalised is a denormal.
  assign exp_lim = work_exp - 1'b1;
  assign shift   = ({{(EXP_W - 3){1'b0}}, lzc} < exp_lim) ? lzc : exp_lim[4:0];
  assign n_mant  = mant << shift;
  assign n_exp   = work_exp - {{(EXP_W - 3){1'b0}}, shift};
`else
  assign n_mant  = mant;
  assign n_exp   = work_exp;
`endif

  always_comb begin
    done = 1'b1;
    word = '0;
    if (pass) begin
      word = '{sign: sign, bexp: EXP_MAX, frac: mant[FRAC_W-1:0]};
    end else if (work_exp >= {2'b00, EXP_MAX}) begin
      word = '{sign: sign, bexp: EXP_MAX, frac: '0};
    end else if (mant == '0) begin
      word = '0;
    end else if (n_mant[MANT_W-1]) begin
      word = '{sign: sign, bexp: n_exp[EXP_W-1:0], frac: n_mant[FRAC_W-1:0]};
    end else if (n_exp == 1) begin
      word = '{sign: sign, bexp: '0, frac: n_mant[FRAC_W-1:0]};
    end else begin
      done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = NORM;
      NORM:    if (done)      state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == OUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mant     <= '0;
      work_exp <= '0;
      sign     <= 1'b0;
      pass     <= 1'b0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mant     <= in_mant;
            sign     <= in_sign;
            pass     <= (in_exp == EXP_MAX);
            work_exp <= (in_exp == EXP_MAX) ? '0 : start_exp;
          end
        end
        NORM: begin
          if (done) begin
            out_data <= word;
          end else begin
            mant     <= mant << 1;
            work_exp <= work_exp - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
